// File: rtl/nv_nvdla_ssync_filt.sv
// Multi-channel strict synchroniser with per-channel glitch filter and rise/fall event pulses.
// Optional macro NVDLA_SSYNC_FILT_BYPASS_EN adds a filt_bypass input that disables filtering.
module nv_nvdla_ssync_filt #(
    parameter int                NUM_CH      = 8,
    parameter int                SYNC_DEPTH  = 3,
    parameter int                FILT_CYCLES = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL   = {NUM_CH{1'b0}}
) (
    input  logic              o_clk,
    input  logic              o_rst,
`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
    input  logic              filt_bypass,
`endif
    input  logic [NUM_CH-1:0] sync_i,
    output logic [NUM_CH-1:0] sync_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              chg_o
);

    localparam int            CW      = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

    if (SYNC_DEPTH < 2 || SYNC_DEPTH > 6) begin : g_bad_depth
        $error("nv_nvdla_ssync_filt: SYNC_DEPTH must be in 2..6");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("nv_nvdla_ssync_filt: NUM_CH must be in 1..32");
    end
    if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
        $error("nv_nvdla_ssync_filt: FILT_CYCLES must be in 1..255");
    end

    logic [NUM_CH-1:0]         sync_q [SYNC_DEPTH];
    logic [NUM_CH-1:0]         s;
    logic [NUM_CH-1:0][CW-1:0] cnt_q;
    logic [NUM_CH-1:0][CW-1:0] cnt_d;
    logic [NUM_CH-1:0]         sync_d;
    logic [NUM_CH-1:0]         rise_d;
    logic [NUM_CH-1:0]         fall_d;
    logic                      chg_d;
    logic                      byp;

`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
    assign byp = filt_bypass;
`else
    assign byp = 1'b0;
`endif

    // Pure flop chain, no logic between stages, so metastability has SYNC_DEPTH-1 cycles to resolve.
    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= sync_i;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_DEPTH-1];

    // A differing value is accepted on the edge where the counter already shows FILT_CYCLES-1 hits.
    always_comb begin
        sync_d = sync_o;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (byp) begin
                cnt_d[c]  = '0;
                sync_d[c] = s[c];
                rise_d[c] = s[c] & ~sync_o[c];
                fall_d[c] = ~s[c] & sync_o[c];
            end else if (s[c] == sync_o[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_MAX) begin
                cnt_d[c]  = '0;
                sync_d[c] = s[c];
                rise_d[c] = s[c];
                fall_d[c] = ~s[c];
            end else begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end
        end
        chg_d = |(rise_d | fall_d);
    end

    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            cnt_q  <= '0;
            sync_o <= RESET_VAL;
            rise_o <= '0;
            fall_o <= '0;
            chg_o  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sync_o <= sync_d;
            rise_o <= rise_d;
            fall_o <= fall_d;
            chg_o  <= chg_d;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_ssync_filt.sv
// Directed bench: a default-depth instance with RESET_VAL=8'hA5 and a minimal SYNC_DEPTH=2/FILT_CYCLES=1 instance.
module tb_nv_nvdla_ssync_filt;

    typedef struct {
        logic [7:0] din;
        int         edges;
        logic [7:0] exp_sync;
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
        logic       exp_chg;
    } vec_t;

    logic       o_clk;
    logic       o_rst;
    logic [7:0] sync_i;
    logic [7:0] sync_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic       chg_o;
    logic [0:0] b_in;
    logic [0:0] b_sync;
    logic [0:0] b_rise;
    logic [0:0] b_fall;
    logic       b_chg;
`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
    logic       filt_bypass;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs [19];

    nv_nvdla_ssync_filt #(
        .NUM_CH(8), .SYNC_DEPTH(3), .FILT_CYCLES(4), .RESET_VAL(8'hA5)
    ) dut_a (
        .o_clk(o_clk),
        .o_rst(o_rst),
`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
        .filt_bypass(filt_bypass),
`endif
        .sync_i(sync_i),
        .sync_o(sync_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .chg_o(chg_o)
    );

    nv_nvdla_ssync_filt #(
        .NUM_CH(1), .SYNC_DEPTH(2), .FILT_CYCLES(1), .RESET_VAL(1'b0)
    ) dut_b (
        .o_clk(o_clk),
        .o_rst(o_rst),
`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
        .filt_bypass(1'b0),
`endif
        .sync_i(b_in),
        .sync_o(b_sync),
        .rise_o(b_rise),
        .fall_o(b_fall),
        .chg_o(b_chg)
    );

    initial o_clk = 1'b0;
    always #5 o_clk = ~o_clk;

    // Drive a new input on the falling edge, then let the given number of rising edges pass.
    task automatic applyStimulus(input logic [7:0] v, input int edges);
        @(negedge o_clk);
        sync_i = v;
        repeat (edges) @(posedge o_clk);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [7:0] act_s, input logic [7:0] act_r,
                               input logic [7:0] act_f, input logic act_c,
                               input logic [7:0] exp_s, input logic [7:0] exp_r,
                               input logic [7:0] exp_f, input logic exp_c);
        checks++;
        if (act_s !== exp_s || act_r !== exp_r || act_f !== exp_f || act_c !== exp_c) begin
            errors++;
            $display("[TB] FAIL %s: got sync=%h rise=%h fall=%h chg=%b, expected sync=%h rise=%h fall=%h chg=%b",
                     name, act_s, act_r, act_f, act_c, exp_s, exp_r, exp_f, exp_c);
        end
    endtask

    task automatic checkA(input string name, input logic [7:0] es, input logic [7:0] er,
                          input logic [7:0] ef, input logic ec);
        checkOutput(name, sync_o, rise_o, fall_o, chg_o, es, er, ef, ec);
    endtask

    task automatic checkB(input string name, input logic es, input logic er,
                          input logic ef, input logic ec);
        checkOutput(name, {7'd0, b_sync}, {7'd0, b_rise}, {7'd0, b_fall}, b_chg,
                    {7'd0, es}, {7'd0, er}, {7'd0, ef}, ec);
    endtask

    initial begin
        // Reset release, latency, glitch rejection, simultaneous events.
        vecs[0]  = '{8'h00,  6, 8'hA5, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{8'h00,  1, 8'h00, 8'h00, 8'hA5, 1'b1};
        vecs[2]  = '{8'h00,  1, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{8'h04,  6, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{8'h04,  1, 8'h04, 8'h04, 8'h00, 1'b1};
        vecs[5]  = '{8'h04,  1, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{8'h05,  3, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{8'h04,  1, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{8'h05,  3, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'h04, 10, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{8'h00,  6, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{8'h00,  1, 8'h00, 8'h00, 8'h04, 1'b1};
        vecs[12] = '{8'hFF,  6, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{8'hFF,  1, 8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[14] = '{8'hFF,  1, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{8'hFF, 18, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[16] = '{8'h0F,  6, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[17] = '{8'h0F,  1, 8'h0F, 8'h00, 8'hF0, 1'b1};
        vecs[18] = '{8'h0F,  1, 8'h0F, 8'h00, 8'h00, 1'b0};

        o_rst  = 1'b1;
        sync_i = 8'h00;
        b_in   = 1'b0;
`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
        filt_bypass = 1'b0;
`endif
        repeat (3) @(posedge o_clk);
        #1;
        checkA("reset_a", 8'hA5, 8'h00, 8'h00, 1'b0);
        checkB("reset_b", 1'b0, 1'b0, 1'b0, 1'b0);

        o_rst = 1'b0;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].din, vecs[i].edges);
            checkA($sformatf("vec%0d", i), vecs[i].exp_sync, vecs[i].exp_rise,
                   vecs[i].exp_fall, vecs[i].exp_chg);
        end

        // Minimal filter: a pulse seen at s for one cycle is accepted three edges after capture.
        @(negedge o_clk);
        b_in = 1'b1;
        @(posedge o_clk); #1;
        checkB("min_e1", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge o_clk);
        b_in = 1'b0;
        @(posedge o_clk); #1;
        checkB("min_e2", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge o_clk); #1;
        checkB("min_e3", 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge o_clk); #1;
        checkB("min_e4", 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge o_clk); #1;
        checkB("min_e5", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while channel 5 holds a partial count of two.
        applyStimulus(8'h2F, 5);
        checkA("pre_rst", 8'h0F, 8'h00, 8'h00, 1'b0);
        @(negedge o_clk);
        o_rst = 1'b1;
        #1;
        checkA("async_rst", 8'hA5, 8'h00, 8'h00, 1'b0);
        @(posedge o_clk); #1;
        checkA("held_rst", 8'hA5, 8'h00, 8'h00, 1'b0);
        o_rst = 1'b0;
        applyStimulus(8'h2F, 6);
        checkA("post_rst_6", 8'hA5, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h2F, 1);
        checkA("post_rst_7", 8'h2F, 8'h0A, 8'h80, 1'b1);
        applyStimulus(8'h2F, 1);
        checkA("post_rst_8", 8'h2F, 8'h00, 8'h00, 1'b0);

`ifdef NVDLA_SSYNC_FILT_BYPASS_EN
        // Bypass: latency SYNC_DEPTH+1 and single-cycle pulses pass through.
        @(negedge o_clk);
        filt_bypass = 1'b1;
        applyStimulus(8'h2D, 3);
        checkA("byp_e3", 8'h2F, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h2D, 1);
        checkA("byp_e4", 8'h2D, 8'h00, 8'h02, 1'b1);
        applyStimulus(8'h2F, 1);
        applyStimulus(8'h2D, 2);
        checkA("byp_p3", 8'h2D, 8'h00, 8'h00, 1'b0);
        @(posedge o_clk); #1;
        checkA("byp_p4", 8'h2F, 8'h02, 8'h00, 1'b1);
        @(posedge o_clk); #1;
        checkA("byp_p5", 8'h2D, 8'h00, 8'h02, 1'b1);
        @(negedge o_clk);
        filt_bypass = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge o_clk); #1;
            checkA($sformatf("byp_off%0d", i), 8'h2D, 8'h00, 8'h00, 1'b0);
        end
        applyStimulus(8'h2F, 3);
        checkA("byp_refilt", 8'h2D, 8'h00, 8'h00, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_ssync_filt.md
Name: nv_nvdla_ssync_filt

Overview:
- Parametrised multi-channel successor to the single-bit 3-flop strict synchroniser.
- Brings NUM_CH asynchronous level signals (straps, interrupts, status lines) into the o_clk domain through a configurable-depth flop chain.
- Adds per-channel stability (glitch) filtering and registered rise/fall event pulses, which the single-bit block does not provide.
- Sits at clock-domain boundaries inside the car/ (clock-and-reset) area, feeding core-side controllers.

Parameters:
- NUM_CH, 8, number of independent channels (1..32).
- SYNC_DEPTH, 3, synchroniser flops per channel (2..6; values outside this range are a compile-time error).
- FILT_CYCLES, 4, consecutive o_clk cycles a synchronised value must hold before it is accepted (1..255).
- RESET_VAL, {NUM_CH{1'b0}}, per-channel reset value of the synchroniser chain and of sync_o.

Ports:
- o_clk, input, 1, destination clock; the only clock in the block.
- o_rst, input, 1, asynchronous active-high reset; deassertion is already synchronised to o_clk by the caller.
- sync_i, input, NUM_CH, asynchronous level inputs; no relation to o_clk is assumed.
- sync_o, output, NUM_CH, filtered and synchronised levels.
- rise_o, output, NUM_CH, one-cycle pulse on a 0->1 change of sync_o.
- fall_o, output, NUM_CH, one-cycle pulse on a 1->0 change of sync_o.
- chg_o, output, 1, OR of all rise_o and fall_o bits (registered, same cycle as those pulses).

Behaviour:
- Reset (o_rst=1, asynchronous):
  - Every synchroniser stage of channel c = RESET_VAL[c].
  - sync_o = RESET_VAL.
  - All filter counters = 0.
  - rise_o, fall_o and chg_o = 0.
- Synchroniser:
  - Per channel: a SYNC_DEPTH-long flop chain on o_clk with no logic between stages.
  - s[c] = last stage.
- Filter:
  - One counter per channel, width clog2(FILT_CYCLES+1).
  - Each o_clk edge, per channel:
    - s==sync_o: cnt<=0.
    - s!=sync_o and cnt==FILT_CYCLES-1: sync_o<=s, cnt<=0, and rise_o<=s or fall_o<=~s.
    - s!=sync_o otherwise: cnt<=cnt+1.
  - rise_o and fall_o are 0 on every edge where sync_o does not change.
- Latency: an input change held stable reaches sync_o exactly SYNC_DEPTH+FILT_CYCLES o_clk edges after first being captured by stage 1.
- Glitch rejection: a pulse present at s for fewer than FILT_CYCLES cycles never reaches sync_o and produces no event.
- Glitch reset: if s returns to the sync_o value before acceptance, the counter clears. Partial counts never accumulate across separate glitches.
- FILT_CYCLES=1: the filter reduces to one register stage and accepts every change that persists for one cycle at s.
- Counter saturation cannot occur: the counter is bounded by FILT_CYCLES-1 by construction.
- Simultaneous events: channels are fully independent; any number of channels may pulse in the same cycle, and chg_o=1 in that cycle.
- Reset mid-operation:
  - Pending counts are discarded.
  - sync_o returns to RESET_VAL with no rise/fall pulse generated for that transition.
  - After reset release, a sync_i differing from RESET_VAL is accepted after the normal latency and produces a normal event.

Optional Feature:
- Macro: NVDLA_SSYNC_FILT_BYPASS_EN.
- Defined:
  - Adds input filt_bypass (1 bit, quasi-static, o_clk domain).
  - When filt_bypass=1, counters are held at 0 and sync_o<=s every cycle. Latency is SYNC_DEPTH+1 edges; rise/fall/chg still pulse on every sync_o change.
  - Toggling filt_bypass from 1 to 0 mid-run causes no spurious event.
- Undefined: no filt_bypass port; the filter is always active.

Test Plan:
- Reset values: NUM_CH=8, RESET_VAL=8'hA5, hold o_rst=1 while driving sync_i=8'h00 -> sync_o=8'hA5, rise_o/fall_o/chg_o=0. Release reset -> after 3+4=7 edges, sync_o=8'h00, fall_o=8'hA5 for one cycle, chg_o=1 for one cycle.
- Latency: defaults, sync_i[2] 0->1 held -> sync_o[2] rises exactly 7 edges after stage-1 capture; rise_o[2]=1 for one cycle only.
- Glitch rejection: FILT_CYCLES=4, sync_i[0] high for 3 cycles then low -> sync_o[0] stays 0 and no events. Two 3-cycle pulses separated by 1 low cycle -> still rejected.
- Simultaneous and minimum filter: sync_i 8'h00->8'hFF, then 8'hFF->8'h0F after 20 cycles -> rise_o=8'hFF for one cycle, later fall_o=8'hF0 for one cycle. With FILT_CYCLES=1, SYNC_DEPTH=2, a 1-cycle-at-s pulse is accepted with latency 3.
- Mid-operation reset: assert o_rst when cnt=2 on channel 5 -> counter cleared, sync_o[5]=RESET_VAL[5], no pulse. After release, full 7-edge latency.
- Bypass (macro defined): filt_bypass=1, sync_i[1] 1-cycle pulse -> sync_o[1] pulses after 4 edges with rise then fall events. Set filt_bypass=0 -> filtering resumes with no spurious pulse.
